fifo_rd_stream: RTL and testbench

//  Read-side consumer for the async FIFO: drives r_req, captures r_data, presents words as valid/ready stream.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/stream_skid_buf.sv | 59 +++++
 rtl/fifo_rd_stream.sv | 93 +++++++++
 tb/tb_fifo_rd_stream.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream consumer.
package fifo_pkg;

    localparam int FIFO_WIDTH_D = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Pointer width that stays legal for a depth of 1.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular skid buffer: BUF_DEPTH words, any depth (wrap is explicit, not power-of-2).
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH_D   = FIFO_WIDTH_D,
    parameter int BUF_DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [WIDTH_D-1:0]             wr_data,
    input  logic                           rd_en,
    output logic [WIDTH_D-1:0]             rd_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] cnt
);

    localparam int PTR_W = ptr_w(BUF_DEPTH);

    logic [WIDTH_D-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; stale words are never visible because cnt gates validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: issues r_req, absorbs the 1-cycle RAM latency in a skid buffer,
// and presents the words as a framed valid/ready stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH_D   = FIFO_WIDTH_D,
    parameter int BUF_DEPTH = 3,
    parameter int PKT_LEN   = 8
) (
    input  logic               r_clk,
    input  logic               r_rst,
    input  logic               en,
    input  logic               r_empty,
    input  logic [WIDTH_D-1:0] r_data,
    output logic               r_req,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH_D-1:0] m_data,
    output logic               m_last,
    output logic               busy
);

    localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int BEAT_W = $clog2(PKT_LEN) + 1;

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic               vld_p1;
    logic [CNT_W-1:0]   cnt;
    logic [BEAT_W-1:0]  beat;
    logic [WIDTH_D-1:0] buf_data;
    logic               pop;

    // Issue only while buffered plus in-flight words leave room, so a capture always fits.
    assign r_req = (state == ST_RUN) && !r_empty && ((int'(cnt) + int'(vld_p1)) < BUF_DEPTH);

    assign m_valid = (cnt != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? buf_data : '0;
    assign m_last  = m_valid && (beat == BEAT_W'(PKT_LEN - 1));
    assign busy    = m_valid || vld_p1;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (en) state_nx = ST_RUN;
            ST_RUN:   if (!en) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                if (en) begin
                    state_nx = ST_RUN;
                end else if ((cnt == '0) && !vld_p1) begin
                    state_nx = ST_IDLE;
                end
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Stage p1: read accepted last cycle, r_data is valid now.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state  <= ST_IDLE;
            vld_p1 <= 1'b0;
            beat   <= '0;
        end else begin
            state  <= state_nx;
            vld_p1 <= r_req;
            if (pop) begin
                beat <= (beat == BEAT_W'(PKT_LEN - 1)) ? '0 : beat + 1'b1;
            end
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            assert ((int'(cnt) + int'(vld_p1)) <= BUF_DEPTH);
        end
    end

    stream_skid_buf #(
        .WIDTH_D   (WIDTH_D),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk     (r_clk),
        .rst     (r_rst),
        .wr_en   (vld_p1),
        .wr_data (r_data),
        .rd_en   (pop),
        .rd_data (buf_data),
        .cnt     (cnt)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO plus a word-queue scoreboard of the stream.
module tb_fifo_rd_stream;

    localparam int WIDTH_D   = 16;
    localparam int BUF_DEPTH = 3;
    localparam int PKT_LEN   = 8;

    logic               r_clk = 1'b0;
    logic               r_rst;
    logic               en;
    logic               r_empty;
    logic [WIDTH_D-1:0] r_data;
    logic               r_req;
    logic               m_valid;
    logic               m_ready;
    logic [WIDTH_D-1:0] m_data;
    logic               m_last;
    logic               busy;

    always #5 r_clk = ~r_clk;

    fifo_rd_stream #(
        .WIDTH_D   (WIDTH_D),
        .BUF_DEPTH (BUF_DEPTH),
        .PKT_LEN   (PKT_LEN)
    ) dut (
        .r_clk   (r_clk),
        .r_rst   (r_rst),
        .en      (en),
        .r_empty (r_empty),
        .r_data  (r_data),
        .r_req   (r_req),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
    );

    typedef struct {
        logic [WIDTH_D-1:0] w;
        int                 avail;
    } ent_t;

    logic [WIDTH_D-1:0] fifo_q[$];
    ent_t               exp_q[$];
    int  cyc       = 0;
    int  beat_n    = 0;
    int  delivered = 0;
    int  errors    = 0;
    int  checks    = 0;
    bit  run_prev  = 1'b0;
    bit  rst_prev  = 1'b1;
    bit  checking  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, want);
        end
    endtask

    // One clock: compare outputs against the word queue, then advance FIFO and model.
    task automatic step();
        logic               exp_valid;
        logic               exp_req;
        logic               do_read;
        logic [WIDTH_D-1:0] w;
        w       = '0;
        r_empty = (fifo_q.size() == 0);
        @(negedge r_clk);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        exp_req   = run_prev && !r_empty && (exp_q.size() < BUF_DEPTH);
        if (checking) begin
            check_val("m_valid", 32'(m_valid), 32'(exp_valid));
            check_val("r_req", 32'(r_req), 32'(exp_req));
            check_val("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (exp_valid) begin
                check_val("m_data", 32'(m_data), 32'(exp_q[0].w));
                check_val("m_last", 32'(m_last), 32'(beat_n == PKT_LEN - 1));
            end else if (rst_prev) begin
                check_val("m_data_rst", 32'(m_data), 32'h0);
                check_val("m_last_rst", 32'(m_last), 32'h0);
            end
        end
        if (exp_valid && m_ready) begin
            void'(exp_q.pop_front());
            beat_n = (beat_n + 1) % PKT_LEN;
            delivered++;
        end
        do_read = r_req && (fifo_q.size() > 0);
        if (do_read) begin
            w = fifo_q.pop_front();
            exp_q.push_back(ent_t'{w, cyc + 2});
        end
        if (r_rst) begin
            exp_q.delete();
            beat_n = 0;
        end
        run_prev = en && !r_rst;
        rst_prev = r_rst;
        @(posedge r_clk);
        cyc++;
        #1 r_data = do_read ? w : WIDTH_D'($urandom);
    endtask

    initial begin
        int d0;
        bit found;
        r_rst   = 1'b1;
        en      = 1'b1;
        m_ready = 1'b1;
        r_data  = '0;
        r_empty = 1'b1;
        for (int i = 1; i <= 16; i++) fifo_q.push_back(WIDTH_D'(i));

        // Reset held two cycles with data waiting and en high.
        step();
        checking = 1'b1;
        step();
        check_val("rst_req", 32'(r_req), 32'h0);
        check_val("rst_valid", 32'(m_valid), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);

        // Full-rate stream of 16 preloaded words.
        r_rst = 1'b0;
        d0 = delivered;
        repeat (20) step();
        check_val("s2_count", 32'(delivered - d0), 32'd16);

        // Backpressure mid-stream.
        for (int i = 1; i <= 16; i++) fifo_q.push_back(WIDTH_D'(16'h0100 + i));
        repeat (6) step();
        m_ready = 1'b0;
        repeat (10) step();
        check_val("s3_occ", 32'(exp_q.size()), 32'(BUF_DEPTH));
        check_val("s3_req_off", 32'(r_req), 32'h0);
        m_ready = 1'b1;
        repeat (25) step();
        check_val("s3_drained", 32'(exp_q.size() + fifo_q.size()), 32'h0);

        // FIFO running empty, then a late write.
        fifo_q.push_back(16'h0031);
        fifo_q.push_back(16'h0032);
        d0 = delivered;
        repeat (8) step();
        check_val("s4_two", 32'(delivered - d0), 32'd2);
        fifo_q.push_back(16'h00AA);
        repeat (6) step();
        check_val("s4_late", 32'(delivered - d0), 32'd3);

        // en dropped with two words buffered and one in flight.
        for (int i = 0; i < 10; i++) fifo_q.push_back(WIDTH_D'(16'h0200 + i));
        m_ready = 1'b0;
        repeat (3) step();
        en      = 1'b0;
        m_ready = 1'b1;
        d0 = delivered;
        repeat (8) step();
        check_val("s5_flushed", 32'(delivered - d0), 32'd3);
        check_val("s5_busy", 32'(busy), 32'h0);
        check_val("s5_fifo_left", 32'(fifo_q.size()), 32'd7);
        en = 1'b1;
        repeat (15) step();
        check_val("s5_resumed", 32'(delivered - d0), 32'd10);

        // Reset one cycle after a read request.
        for (int i = 0; i < 12; i++) fifo_q.push_back(WIDTH_D'(16'h0300 + i));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (r_req) found = 1'b1;
        end
        check_val("s6_req_seen", 32'(found), 32'h1);
        step();
        r_rst = 1'b1;
        step();
        r_rst = 1'b0;
        check_val("s6_valid", 32'(m_valid), 32'h0);
        check_val("s6_busy", 32'(busy), 32'h0);
        repeat (25) step();

        // Randomised traffic with occasional resets.
        repeat (600) begin
            en      = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 9) < 7);
            r_rst   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 1) == 1) fifo_q.push_back(WIDTH_D'($urandom));
            step();
        end
        r_rst   = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 2000 && (fifo_q.size() + exp_q.size()) != 0; i++) step();
        check_val("final_drained", 32'(fifo_q.size() + exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
